// File: rtl/arp_rx_parser.sv
// ARP receive parser: captures the 28-byte ARP body from the post-MAC stream,
// validates it and holds one result behind a valid/ready handshake.
// Statistics counters are built only when ARP_RX_STATS_EN is defined.
module arp_rx_parser #(
  parameter int DATA_W    = 32,
  parameter bit FILTER_IP = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       dev_ip_addr_i,
  input  logic              rcv_op_i,
  input  logic              rcv_op_st_i,
  input  logic              rcv_op_end_i,
  input  logic [DATA_W-1:0] rcv_data_i,
  input  logic [15:0]       prot_type_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [15:0]       opcode_o,
  output logic              is_grat_o,
  output logic [47:0]       sender_haddr_o,
  output logic [47:0]       target_haddr_o,
  output logic [31:0]       sender_paddr_o,
  output logic [31:0]       target_paddr_o,
  output logic [15:0]       rx_ok_cnt_o,
  output logic [15:0]       rx_drop_cnt_o
);

  localparam int NB = DATA_W / 8;
  localparam logic [8:0] NB9 = 9'(NB);

  typedef enum logic [1:0] {IDLE, RX, CHECK} state_t;
  state_t state, state_nxt;

  logic [7:0] byte_cnt;
  logic [7:0] cap [28];
  logic [8:0] lane_pos [NB];
  logic [8:0] cnt_sum;
  logic       start_ok, beat_cap, abort, frame_ok, load;

  logic [15:0] htype, ptype, opcode;
  logic [7:0]  hlen, plen;
  logic [47:0] sha, tha;
  logic [31:0] spa, tpa;

  assign htype  = {cap[0], cap[1]};
  assign ptype  = {cap[2], cap[3]};
  assign hlen   = cap[4];
  assign plen   = cap[5];
  assign opcode = {cap[6], cap[7]};
  assign sha    = {cap[8], cap[9], cap[10], cap[11], cap[12], cap[13]};
  assign spa    = {cap[14], cap[15], cap[16], cap[17]};
  assign tha    = {cap[18], cap[19], cap[20], cap[21], cap[22], cap[23]};
  assign tpa    = {cap[24], cap[25], cap[26], cap[27]};

  assign start_ok = rcv_op_i & rcv_op_st_i & (prot_type_i == 16'h0806);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // A start beat in RX aborts the current frame; it restarts capture only if it is an ARP start.
  always_comb begin
    state_nxt = state;
    beat_cap  = 1'b0;
    abort     = 1'b0;
    case (state)
      RX: begin
        if (rcv_op_i) begin
          if (rcv_op_st_i) begin
            abort = 1'b1;
            if (start_ok) begin
              beat_cap  = 1'b1;
              state_nxt = rcv_op_end_i ? CHECK : RX;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            beat_cap = 1'b1;
            if (rcv_op_end_i) state_nxt = CHECK;
          end
        end
      end
      default: begin
        if (start_ok) begin
          beat_cap  = 1'b1;
          state_nxt = rcv_op_end_i ? CHECK : RX;
        end else begin
          state_nxt = IDLE;
        end
      end
    endcase
  end

  always_comb begin
    for (int i = 0; i < NB; i++)
      lane_pos[i] = (rcv_op_st_i ? 9'd0 : {1'b0, byte_cnt}) + 9'(i);
    cnt_sum = {1'b0, byte_cnt} + NB9;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
      for (int i = 0; i < 28; i++) cap[i] <= '0;
    end else if (beat_cap) begin
      if (rcv_op_st_i)    byte_cnt <= NB9[7:0];
      else if (cnt_sum[8]) byte_cnt <= 8'hFF;
      else                byte_cnt <= cnt_sum[7:0];
      for (int i = 0; i < NB; i++)
        if (lane_pos[i] < 9'd28)
          cap[lane_pos[i][4:0]] <= rcv_data_i[DATA_W-1-8*i -: 8];
    end
  end

  assign frame_ok = (byte_cnt >= 8'd28) && (htype == 16'h0001) && (ptype == 16'h0800) &&
                    (hlen == 8'd6) && (plen == 8'd4) &&
                    ((opcode == 16'd1) || (opcode == 16'd2)) &&
                    ((FILTER_IP == 1'b0) || (tpa == dev_ip_addr_i) || (spa == tpa));

  // A passing frame only loads when the holding slot is free or being emptied this cycle.
  assign load = (state == CHECK) && frame_ok && (!out_valid_o || out_ready_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_o    <= 1'b0;
      opcode_o       <= '0;
      is_grat_o      <= 1'b0;
      sender_haddr_o <= '0;
      target_haddr_o <= '0;
      sender_paddr_o <= '0;
      target_paddr_o <= '0;
    end else if (load) begin
      out_valid_o    <= 1'b1;
      opcode_o       <= opcode;
      is_grat_o      <= (spa == tpa);
      sender_haddr_o <= sha;
      target_haddr_o <= tha;
      sender_paddr_o <= spa;
      target_paddr_o <= tpa;
    end else if (out_ready_i) begin
      out_valid_o    <= 1'b0;
    end
  end

`ifdef ARP_RX_STATS_EN
  logic        drop;
  logic [15:0] ok_cnt, drop_cnt;

  assign drop = abort || ((state == CHECK) && !load);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ok_cnt   <= '0;
      drop_cnt <= '0;
    end else begin
      if (load) ok_cnt   <= ok_cnt + 16'd1;
      if (drop) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign rx_ok_cnt_o   = ok_cnt;
  assign rx_drop_cnt_o = drop_cnt;
`else
  logic unused_stats;
  assign unused_stats  = abort;
  assign rx_ok_cnt_o   = 16'h0000;
  assign rx_drop_cnt_o = 16'h0000;
`endif

endmodule

// File: doc/arp_rx_parser.md
# arp_rx_parser

Parametrised ARP frame parser that follows the Ethernet MAC receive path. It takes the post-MAC payload stream at a configurable bus width and extracts every field of the 28-byte ARP body. It validates the fields, filters on the device IP, and presents one result per frame through a valid/ready handshake with a one-deep holding register. Requests, replies and gratuitous ARP are all handled; the block feeds the ARP reply generator and the ARP cache.

## Interface
Parameters:
- DATA_W, 32, receive bus width in bits; legal values 8, 16, 32, 64; big-endian (byte 0 of the frame is in bits [DATA_W-1 -: 8]).
- FILTER_IP, 1, 1 = accept only frames whose target IP equals dev_ip_addr_i (or gratuitous frames); 0 = accept every well-formed frame.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- dev_ip_addr_i  in  32  device IPv4 address; static while frames are in flight.
- rcv_op_i  in  1  beat valid.
- rcv_op_st_i  in  1  first beat of the payload; meaningful only with rcv_op_i.
- rcv_op_end_i  in  1  last beat of the payload; meaningful only with rcv_op_i; may coincide with rcv_op_st_i.
- rcv_data_i  in  DATA_W  payload beat.
- prot_type_i  in  16  EtherType; stable for the whole frame.
- out_valid_o  out  1  result available.
- out_ready_i  in  1  consumer accepts the result.
- opcode_o  out  16  ARP operation code (1 = request, 2 = reply).
- is_grat_o  out  1  sender IP equals target IP.
- sender_haddr_o / target_haddr_o  out  48  MAC addresses.
- sender_paddr_o / target_paddr_o  out  32  IP addresses.
- rx_ok_cnt_o  out  16  count of accepted frames.
- rx_drop_cnt_o  out  16  count of dropped frames.

## Operation
- States: IDLE, RX, CHECK.
- IDLE -> RX: on a beat with rcv_op_st_i=1 and prot_type_i=0x0806. Beats that do not meet this are ignored.
- On the start beat, byte_cnt is loaded with DATA_W/8. Each later beat adds DATA_W/8 to byte_cnt, which is 8 bits and saturates at 255.
- Capture: for frame byte position p < 28, the byte is written into a 28-byte capture buffer. Bytes at p >= 28 (padding) are discarded.
- RX -> CHECK: on a beat with rcv_op_end_i=1, including a start beat that is also the end beat.
- Restart: a start beat arriving in RX restarts the capture. The aborted frame counts as one drop.
- CHECK lasts exactly one cycle, then goes to IDLE. The frame passes only if all of these hold:
  - byte_cnt >= 28;
  - htype = 0x0001, ptype = 0x0800, hlen = 6, plen = 4;
  - opcode is 1 or 2;
  - FILTER_IP = 0, or tpa = dev_ip_addr_i, or spa = tpa.
- Pass with the slot free (out_valid_o = 0, or out_ready_i = 1 in the same cycle): all output fields load and out_valid_o is set. rx_ok_cnt_o increments.
- Pass with the slot busy (out_valid_o = 1 and out_ready_i = 0): the frame is dropped and the held result is untouched. rx_drop_cnt_o increments.
- Fail: rx_drop_cnt_o increments.
- Output handshake:
  - out_valid_o stays high until out_ready_i is sampled high.
  - Output fields are stable while out_valid_o = 1.
  - out_valid_o clears on the accepting edge unless a new result loads on the same edge, in which case it stays high with the new data.
- Counters are 16 bits and wrap.

## Timing
- End beat sampled at edge E. State is CHECK during the next cycle, and out_valid_o is high after edge E+1. Latency is 2 edges from the end beat to valid.
- Back-to-back frames with one idle cycle between them are fully supported. A start beat that arrives during CHECK is accepted and enters RX.
- Reset values: out_valid_o = 0, is_grat_o = 0, and opcode_o, all address outputs, both counters and byte_cnt = 0. State resets to IDLE.
- Reset asserted mid-frame clears everything immediately. Frame data arriving after reset is ignored until the next start beat.

## Configuration
- ARP_RX_STATS_EN:
  - Defined: rx_ok_cnt_o and rx_drop_cnt_o count as described above.
  - Undefined: no counter registers are built, and both ports are tied to 16'h0000.
- Handshake and parsing behaviour are identical either way.

## Test plan
- DATA_W=32, FILTER_IP=1, dev IP 192.168.1.10: send a request with SHA 00:11:22:33:44:55, SPA 192.168.1.1, TPA 192.168.1.10, followed by 18 bytes of padding. Required: out_valid_o is high 2 edges after the end beat; opcode_o=1; sender_haddr_o=0x001122334455; target_paddr_o=0xC0A8010A; rx_ok_cnt_o=1.
- Same frame with TPA 192.168.1.20: no out_valid_o and rx_drop_cnt_o=1. Repeat with FILTER_IP=0: accepted.
- Gratuitous reply with SPA = TPA = 10.0.0.5 and FILTER_IP=1: accepted with is_grat_o=1 and opcode_o=2.
- Frame ending after 24 bytes, and a separate frame with hlen=8: each is dropped and rx_drop_cnt_o increments once per frame.
- Hold out_ready_i=0 and send two valid frames: the first is held unchanged and the second is dropped (ok=1, drop=1). Then send a third frame with out_ready_i=1 in the CHECK cycle: the third result replaces the first and out_valid_o stays high.
- DATA_W=64 and DATA_W=8 regressions of the first scenario give identical field values. Asserting rst_n low at byte 12 of a frame clears all outputs, and the next frame parses correctly.
